// File: rtl/exec_sched_if.sv
// exec_sched_if: bundles the issue, FPU request/response, retire and flush signals of exec_sched.
//   slave  - scheduler side (accepts issue, drives FPU request and retire)
//   master - environment side (drives issue, FPU response, out_ready and flush)
interface exec_sched_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned RD_WIDTH   = 5
) ();
   // Issue handshake and payload
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_unit;
   logic [3:0]            in_op;
   logic [DATA_WIDTH-1:0] in_op1;
   logic [DATA_WIDTH-1:0] in_op2;
   logic [RD_WIDTH-1:0]   in_rdist;
   // FPU request / response
   logic                  fpu_req_valid;
   logic [3:0]            fpu_req_op;
   logic [DATA_WIDTH-1:0] fpu_req_a;
   logic [DATA_WIDTH-1:0] fpu_req_b;
   logic                  fpu_resp_valid;
   logic [DATA_WIDTH-1:0] fpu_resp_data;
   // Retire handshake
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_result;
   logic [RD_WIDTH-1:0]   out_rdist;
   logic                  out_unit;
   // Pipeline flush
   logic                  flush;

   modport slave (
      input  in_valid, in_unit, in_op, in_op1, in_op2, in_rdist,
      output in_ready,
      output fpu_req_valid, fpu_req_op, fpu_req_a, fpu_req_b,
      input  fpu_resp_valid, fpu_resp_data,
      output out_valid, out_result, out_rdist, out_unit,
      input  out_ready,
      input  flush
   );

   modport master (
      output in_valid, in_unit, in_op, in_op1, in_op2, in_rdist,
      input  in_ready,
      input  fpu_req_valid, fpu_req_op, fpu_req_a, fpu_req_b,
      output fpu_resp_valid, fpu_resp_data,
      input  out_valid, out_result, out_rdist, out_unit,
      output out_ready,
      output flush
   );
endinterface

// File: rtl/exec_sched.sv
// exec_sched: in-order execution scheduler. ALU ops complete at issue; FPU ops are sent to an
// external FPU and complete when its in-order response arrives. Results retire strictly in
// issue order from a circular completion queue of DEPTH entries.
// Ports:
//   CLK   - clock
//   reset - synchronous active-low reset
//   bus   - exec_sched_if.slave: issue, FPU request/response, retire and flush signals
module exec_sched #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned RD_WIDTH   = 5
) (
   input logic         CLK,
   input logic         reset,
   exec_sched_if.slave bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned SW = $clog2(DATA_WIDTH);
   // Discard counter is wider than the queue: repeated flushes can stack up pending responses
   localparam int unsigned DW = CW + 4;

   logic [PW-1:0]         head_q, head_d, tail_q, tail_d, fptr_q, fptr_d, fptr_scan;
   logic [CW-1:0]         count_q, count_d, fout_q, fout_d;
   logic [DW-1:0]         disc_q, disc_d;
   logic [DEPTH-1:0]      done_q, done_d, unit_q;
   logic [DATA_WIDTH-1:0] result_q [DEPTH];
   logic [RD_WIDTH-1:0]   rdist_q [DEPTH];
   logic [DATA_WIDTH-1:0] alu_res;
   logic [SW-1:0]         shamt;
   logic                  issue, fpu_issue, retire, resp_wr;

   assign bus.in_ready = (count_q < CW'(DEPTH)) && !bus.flush;
   assign issue        = bus.in_valid && bus.in_ready;
   assign fpu_issue    = issue && bus.in_unit;
   assign bus.out_valid = (count_q != '0) && done_q[head_q];
   assign retire       = bus.out_valid && bus.out_ready;
   // A response updates the queue only when nothing is left to discard and no flush is in progress
   assign resp_wr      = bus.fpu_resp_valid && !bus.flush && (disc_q == '0) && (fout_q != '0);

   assign bus.fpu_req_valid = fpu_issue;
   assign bus.fpu_req_op    = bus.in_op;
   assign bus.fpu_req_a     = bus.in_op1;
   assign bus.fpu_req_b     = bus.in_op2;

   // Retire outputs are forced to zero when the head is not valid
   assign bus.out_result = bus.out_valid ? result_q[head_q] : '0;
   assign bus.out_rdist  = bus.out_valid ? rdist_q[head_q] : '0;
   assign bus.out_unit   = bus.out_valid ? unit_q[head_q] : 1'b0;

   assign shamt = bus.in_op2[SW-1:0];

   always_comb begin
      alu_res = '0;
      case (bus.in_op)
         4'd0:    alu_res = bus.in_op1 + bus.in_op2;
         4'd1:    alu_res = bus.in_op1 - bus.in_op2;
         4'd2:    alu_res = bus.in_op1 & bus.in_op2;
         4'd3:    alu_res = bus.in_op1 | bus.in_op2;
         4'd4:    alu_res = bus.in_op1 ^ bus.in_op2;
         4'd5:    alu_res = bus.in_op1 << shamt;
         4'd6:    alu_res = bus.in_op1 >> shamt;
         4'd7:    alu_res = $signed(bus.in_op1) >>> shamt;
         4'd8:    alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(bus.in_op1) < $signed(bus.in_op2)};
         4'd9:    alu_res = {{(DATA_WIDTH-1){1'b0}}, bus.in_op1 < bus.in_op2};
         default: alu_res = '0;
      endcase
   end

   // Next FPU entry after the current one. Only used while another FPU op is outstanding, in
   // which case the first FPU-tagged slot after fptr_q lies inside the occupied region.
   always_comb begin
      logic [PW-1:0] idx;
      logic          found;
      fptr_scan = fptr_q;
      found     = 1'b0;
      idx       = '0;
      for (int unsigned k = 1; k < DEPTH; k++) begin
         idx = fptr_q + PW'(k);
         if (!found && unit_q[idx]) begin
            fptr_scan = idx;
            found     = 1'b1;
         end
      end
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      fptr_d  = fptr_q;
      count_d = count_q + CW'(issue) - CW'(retire);
      fout_d  = fout_q + CW'(fpu_issue) - CW'(resp_wr);
      disc_d  = disc_q;
      done_d  = done_q;

      if (issue)  tail_d = tail_q + 1'b1;
      if (retire) begin
         head_d         = head_q + 1'b1;
         done_d[head_q] = 1'b0;
      end
      if (issue)   done_d[tail_q] = !bus.in_unit;
      if (resp_wr) done_d[fptr_q] = 1'b1;

      if (resp_wr) begin
         if (fout_q > CW'(1))  fptr_d = fptr_scan;
         else if (fpu_issue)   fptr_d = tail_q;
      end else if (fpu_issue && fout_q == '0) begin
         fptr_d = tail_q;
      end

      if (bus.fpu_resp_valid && disc_q != '0) disc_d = disc_q - 1'b1;

      if (bus.flush) begin
         head_d  = '0;
         tail_d  = '0;
         fptr_d  = '0;
         count_d = '0;
         fout_d  = '0;
         done_d  = '0;
         // Every pending response gets discarded; one arriving now is already consumed
         if (bus.fpu_resp_valid && (disc_q != '0 || fout_q != '0)) begin
            disc_d = disc_q + DW'(fout_q) - 1'b1;
         end else begin
            disc_d = disc_q + DW'(fout_q);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         fptr_q  <= '0;
         count_q <= '0;
         fout_q  <= '0;
         disc_q  <= '0;
         done_q  <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         fptr_q  <= fptr_d;
         count_q <= count_d;
         fout_q  <= fout_d;
         disc_q  <= disc_d;
         done_q  <= done_d;
      end
   end

   // Payload storage needs no reset: it is only observed through done bits
   always_ff @(posedge CLK) begin
      if (issue) begin
         result_q[tail_q] <= bus.in_unit ? '0 : alu_res;
         rdist_q[tail_q]  <= bus.in_rdist;
         unit_q[tail_q]   <= bus.in_unit;
      end
      if (resp_wr) result_q[fptr_q] <= bus.fpu_resp_data;
   end
endmodule

// File: tb/tb_exec_sched.sv
module tb_exec_sched;
   logic clk;
   logic reset;
   int   checks;
   int   failures;

   exec_sched_if #(.DATA_WIDTH(32), .RD_WIDTH(5)) bus ();

   exec_sched #(.DATA_WIDTH(32), .DEPTH(4), .RD_WIDTH(5)) dut (
      .CLK   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid       = 1'b0;
      bus.fpu_resp_valid = 1'b0;
      bus.flush          = 1'b0;
   endtask

   task automatic drive(input logic unit, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
      bus.in_valid = 1'b1;
      bus.in_unit  = unit;
      bus.in_op    = op;
      bus.in_op1   = a;
      bus.in_op2   = b;
      bus.in_rdist = rd;
   endtask

   task automatic expect_out(input string tag, input logic [31:0] res, input logic [4:0] rd,
                             input logic unit);
      check({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, ".result"}, 64'(bus.out_result), 64'(res));
      check({tag, ".rdist"}, 64'(bus.out_rdist), 64'(rd));
      check({tag, ".unit"}, 64'(bus.out_unit), 64'(unit));
   endtask

   logic [3:0]  w_op  [10];
   logic [31:0] w_a   [10];
   logic [31:0] w_b   [10];
   logic [31:0] w_exp [10];

   initial begin
      int issued;
      int retired;
      int cyc;
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      bus.out_ready     = 1'b0;
      bus.in_unit       = 1'b0;
      bus.in_op         = '0;
      bus.in_op1        = '0;
      bus.in_op2        = '0;
      bus.in_rdist      = '0;
      bus.fpu_resp_data = '0;
      idle();

      w_op[0] = 4'd0;  w_a[0] = 32'hFFFFFFFF; w_b[0] = 32'd2;         w_exp[0] = 32'h00000001;
      w_op[1] = 4'd1;  w_a[1] = 32'd0;        w_b[1] = 32'd1;         w_exp[1] = 32'hFFFFFFFF;
      w_op[2] = 4'd4;  w_a[2] = 32'hAAAA5555; w_b[2] = 32'hFFFF0000; w_exp[2] = 32'h55555555;
      w_op[3] = 4'd6;  w_a[3] = 32'h80000000; w_b[3] = 32'd31;        w_exp[3] = 32'h00000001;
      w_op[4] = 4'd8;  w_a[4] = 32'hFFFFFFFF; w_b[4] = 32'd1;         w_exp[4] = 32'h00000001;
      w_op[5] = 4'd9;  w_a[5] = 32'hFFFFFFFF; w_b[5] = 32'd1;         w_exp[5] = 32'h00000000;
      w_op[6] = 4'd12; w_a[6] = 32'd5;        w_b[6] = 32'd6;         w_exp[6] = 32'h00000000;
      w_op[7] = 4'd7;  w_a[7] = 32'h7FFFFFF0; w_b[7] = 32'd4;         w_exp[7] = 32'h07FFFFFF;
      w_op[8] = 4'd5;  w_a[8] = 32'h00000001; w_b[8] = 32'h3F;        w_exp[8] = 32'h80000000;
      w_op[9] = 4'd2;  w_a[9] = 32'h12345678; w_b[9] = 32'hFF00FF00; w_exp[9] = 32'h12005600;

      // Reset state
      tick();
      tick();
      check("rst.out_valid", 64'(bus.out_valid), 64'd0);
      check("rst.fpu_req_valid", 64'(bus.fpu_req_valid), 64'd0);
      check("rst.out_result", 64'(bus.out_result), 64'd0);
      check("rst.out_rdist", 64'(bus.out_rdist), 64'd0);
      check("rst.out_unit", 64'(bus.out_unit), 64'd0);
      reset = 1'b1;
      tick();
      check("rst.in_ready", 64'(bus.in_ready), 64'd1);

      // Single ALU op: 7 + 5 -> 12 one cycle later
      bus.out_ready = 1'b1;
      drive(1'b0, 4'd0, 32'd7, 32'd5, 5'd3);
      #1;
      check("alu1.fpu_req_valid", 64'(bus.fpu_req_valid), 64'd0);
      tick();
      idle();
      #1;
      expect_out("alu1", 32'd12, 5'd3, 1'b0);
      tick();
      check("alu1.after", 64'(bus.out_valid), 64'd0);

      // Ordering: FPU then ALU sub; ALU must wait for the FPU result
      drive(1'b1, 4'd3, 32'h11111111, 32'h22222222, 5'd1);
      #1;
      check("ord.req_valid", 64'(bus.fpu_req_valid), 64'd1);
      check("ord.req_op", 64'(bus.fpu_req_op), 64'd3);
      check("ord.req_a", 64'(bus.fpu_req_a), 64'h11111111);
      check("ord.req_b", 64'(bus.fpu_req_b), 64'h22222222);
      tick();
      drive(1'b0, 4'd1, 32'd2, 32'd3, 5'd2);
      tick();
      idle();
      #1;
      check("ord.wait1", 64'(bus.out_valid), 64'd0);
      tick();
      check("ord.wait2", 64'(bus.out_valid), 64'd0);
      bus.fpu_resp_valid = 1'b1;
      bus.fpu_resp_data  = 32'h40400000;
      tick();
      bus.fpu_resp_valid = 1'b0;
      #1;
      expect_out("ord.fpu", 32'h40400000, 5'd1, 1'b1);
      tick();
      expect_out("ord.alu", 32'hFFFFFFFF, 5'd2, 1'b0);
      tick();
      check("ord.empty", 64'(bus.out_valid), 64'd0);

      // Full / backpressure
      bus.out_ready = 1'b0;
      drive(1'b0, 4'd2, 32'h0000F0F0, 32'h00000FF0, 5'd4);
      tick();
      drive(1'b0, 4'd3, 32'h0000F000, 32'h0000000F, 5'd5);
      tick();
      drive(1'b0, 4'd5, 32'h00000001, 32'h00000024, 5'd6);
      tick();
      drive(1'b0, 4'd7, 32'h80000000, 32'h00000004, 5'd7);
      tick();
      drive(1'b0, 4'd0, 32'd1, 32'd1, 5'd9);
      #1;
      check("full.in_ready", 64'(bus.in_ready), 64'd0);
      tick();
      idle();
      bus.out_ready = 1'b1;
      #1;
      check("full.still", 64'(bus.in_ready), 64'd0);
      expect_out("full.r0", 32'h000000F0, 5'd4, 1'b0);
      tick();
      check("full.ready_back", 64'(bus.in_ready), 64'd1);
      expect_out("full.r1", 32'h0000F00F, 5'd5, 1'b0);
      tick();
      expect_out("full.r2", 32'h00000010, 5'd6, 1'b0);
      tick();
      expect_out("full.r3", 32'hF8000000, 5'd7, 1'b0);
      tick();
      check("full.no_fifth", 64'(bus.out_valid), 64'd0);

      // Flush with two FPU ops outstanding
      drive(1'b1, 4'd0, 32'd1, 32'd2, 5'd10);
      tick();
      drive(1'b1, 4'd0, 32'd3, 32'd4, 5'd11);
      tick();
      drive(1'b1, 4'd0, 32'd5, 32'd6, 5'd30);
      bus.flush = 1'b1;
      #1;
      check("fl.in_ready", 64'(bus.in_ready), 64'd0);
      check("fl.req_valid", 64'(bus.fpu_req_valid), 64'd0);
      tick();
      idle();
      #1;
      check("fl.out_valid", 64'(bus.out_valid), 64'd0);
      drive(1'b0, 4'd3, 32'h0000000F, 32'h00000030, 5'd12);
      bus.fpu_resp_valid = 1'b1;
      bus.fpu_resp_data  = 32'h0000DEAD;
      tick();
      bus.in_valid      = 1'b0;
      bus.fpu_resp_data = 32'h0000BEEF;
      #1;
      expect_out("fl.alu", 32'h0000003F, 5'd12, 1'b0);
      tick();
      idle();
      #1;
      check("fl.drop", 64'(bus.out_valid), 64'd0);
      drive(1'b1, 4'd0, 32'd0, 32'd0, 5'd13);
      tick();
      idle();
      bus.fpu_resp_valid = 1'b1;
      bus.fpu_resp_data  = 32'h00001234;
      tick();
      bus.fpu_resp_valid = 1'b0;
      #1;
      expect_out("fl.newfpu", 32'h00001234, 5'd13, 1'b1);
      tick();

      // Response arriving in the flush cycle counts as dropped
      drive(1'b1, 4'd0, 32'd0, 32'd0, 5'd14);
      tick();
      idle();
      bus.flush          = 1'b1;
      bus.fpu_resp_valid = 1'b1;
      bus.fpu_resp_data  = 32'h00000BAD;
      tick();
      idle();
      drive(1'b1, 4'd0, 32'd0, 32'd0, 5'd15);
      tick();
      idle();
      bus.fpu_resp_valid = 1'b1;
      bus.fpu_resp_data  = 32'h00005555;
      tick();
      bus.fpu_resp_valid = 1'b0;
      #1;
      expect_out("flr.fpu", 32'h00005555, 5'd15, 1'b1);
      tick();

      // Wrap-around with random backpressure
      issued  = 0;
      retired = 0;
      cyc     = 0;
      while (retired < 10 && cyc < 200) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         if (issued < 10) drive(1'b0, w_op[issued], w_a[issued], w_b[issued], 5'(16 + issued));
         else bus.in_valid = 1'b0;
         #1;
         if (bus.out_valid && bus.out_ready) begin
            check($sformatf("wrap.res%0d", retired), 64'(bus.out_result), 64'(w_exp[retired]));
            check($sformatf("wrap.rd%0d", retired), 64'(bus.out_rdist), 64'(16 + retired));
            retired++;
         end
         if (bus.in_valid && bus.in_ready) issued++;
         tick();
         cyc++;
      end
      idle();
      check("wrap.retired", 64'(retired), 64'd10);
      bus.out_ready = 1'b1;
      #1;
      check("wrap.empty", 64'(bus.out_valid), 64'd0);

      // Simultaneous issue, FPU response and retire
      bus.out_ready = 1'b0;
      drive(1'b0, 4'd0, 32'd1, 32'd2, 5'd20);
      tick();
      drive(1'b1, 4'd0, 32'd0, 32'd0, 5'd21);
      tick();
      drive(1'b0, 4'd0, 32'd10, 32'd20, 5'd22);
      bus.fpu_resp_valid = 1'b1;
      bus.fpu_resp_data  = 32'h0000CAFE;
      bus.out_ready      = 1'b1;
      #1;
      expect_out("sim.head", 32'd3, 5'd20, 1'b0);
      tick();
      idle();
      bus.out_ready = 1'b0;
      drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd23);
      tick();
      drive(1'b0, 4'd0, 32'd0, 32'd0, 5'd24);
      tick();
      idle();
      #1;
      check("sim.count_full", 64'(bus.in_ready), 64'd0);
      bus.out_ready = 1'b1;
      #1;
      expect_out("sim.fpu", 32'h0000CAFE, 5'd21, 1'b1);
      tick();
      expect_out("sim.alu", 32'd30, 5'd22, 1'b0);
      tick();
      expect_out("sim.r23", 32'd0, 5'd23, 1'b0);
      tick();
      expect_out("sim.r24", 32'd0, 5'd24, 1'b0);
      tick();
      check("sim.empty", 64'(bus.out_valid), 64'd0);

      // Reset overrides a same-cycle issue
      bus.out_ready = 1'b0;
      drive(1'b0, 4'd0, 32'd1, 32'd1, 5'd25);
      tick();
      reset = 1'b0;
      drive(1'b0, 4'd0, 32'd2, 32'd2, 5'd26);
      tick();
      reset = 1'b1;
      idle();
      #1;
      check("rst2.out_valid", 64'(bus.out_valid), 64'd0);
      check("rst2.in_ready", 64'(bus.in_ready), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
